// File: rtl/psram_bus_if.sv
// psram_bus_if: request/response front end for a PSRAM transfer core.
// Queues host requests in a small FIFO and issues one transfer at a time
// to the core. It returns responses in request order. Misaligned requests,
// and requests made while the controller is disabled, get an error
// response and are never issued.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   cfg_en_i                controller enable
//   req_* (valid/ready)     host request: we, byte addr, wdata, wstrb
//   rsp_* (valid/ready)     host response: rdata, err
//   xfer_valid_o/ready_i    transfer request handshake to the core
//   xfer_rdwr_o             1=read, 0=write
//   xfer_done_i             one-cycle completion pulse from the core
//   bus_addr_o/wr_data_o/wr_mask_o  FIFO head, presented to the core
//   bus_rd_data_i           read data from the core
module psram_bus_if #(
  parameter int unsigned REQ_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cfg_en_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        xfer_valid_o,
  output logic        xfer_rdwr_o,
  input  logic        xfer_ready_i,
  input  logic        xfer_done_i,
  output logic [31:0] bus_addr_o,
  output logic [63:0] bus_wr_data_o,
  output logic [7:0]  bus_wr_mask_o,
  input  logic [63:0] bus_rd_data_i
);

  localparam int unsigned PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Request FIFO storage and pointers
  logic              fifo_we_q    [REQ_DEPTH];
  logic [31:0]       fifo_addr_q  [REQ_DEPTH];
  logic [63:0]       fifo_wdata_q [REQ_DEPTH];
  logic [7:0]        fifo_wstrb_q [REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  state_e            state_q;
  logic              xfer_valid_q;
  logic              rsp_valid_q;
  logic [63:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              head_we;
  logic [31:0]       head_addr;
  logic [63:0]       head_wdata;
  logic [7:0]        head_wstrb;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(REQ_DEPTH));
  // Ready depends only on stored occupancy, so a same-cycle pop never frees a slot early.
  assign req_ready_o = ~fifo_full;
  assign push        = req_valid_i & ~fifo_full;
  // Head stays queued until its response has been handed over.
  assign pop         = (state_q == S_RESP) & rsp_ready_i;

  assign head_we    = fifo_we_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];
  assign head_wstrb = fifo_wstrb_q[rd_ptr_q];

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO payload write; contents are only meaningful below count_q
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= req_we_i;
      fifo_addr_q[wr_ptr_q]  <= req_addr_i;
      fifo_wdata_q[wr_ptr_q] <= req_wdata_i;
      fifo_wstrb_q[wr_ptr_q] <= req_wstrb_i;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Transfer sequencer with registered handshake and response outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      xfer_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            if ((head_addr[2:0] == 3'b000) && cfg_en_i) begin
              state_q      <= S_ISSUE;
              xfer_valid_q <= 1'b1;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (xfer_ready_i) begin
            state_q      <= S_WAIT;
            xfer_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          // Enable is deliberately not looked at here: an issued transfer always completes.
          if (xfer_done_i) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= head_we ? 64'd0 : bus_rd_data_i;
            rsp_err_q   <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xfer_valid_o  = xfer_valid_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;

  // Head presented to the core; idle value when nothing is queued
  assign xfer_rdwr_o   = fifo_empty ? 1'b1  : ~head_we;
  assign bus_addr_o    = fifo_empty ? 32'd0 : head_addr;
  assign bus_wr_data_o = fifo_empty ? 64'd0 : head_wdata;
  assign bus_wr_mask_o = fifo_empty ? 8'd0  : head_wstrb;

endmodule

// File: tb/tb_psram_bus_if.sv
// Testbench for psram_bus_if: directed requests, a simple core model,
// and scoreboards for transfers and responses.
module tb_psram_bus_if;

  logic        clk;
  logic        rst_n_i;
  logic        cfg_en_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wstrb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        xfer_valid_o;
  logic        xfer_rdwr_o;
  logic        xfer_ready_i;
  logic        xfer_done_i;
  logic [31:0] bus_addr_o;
  logic [63:0] bus_wr_data_o;
  logic [7:0]  bus_wr_mask_o;
  logic [63:0] bus_rd_data_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        rdwr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } xfer_t;

  rsp_t  rsp_q[$];
  xfer_t xq[$];

  int          core_delay = 20;
  logic [63:0] core_rdata = 64'h1122334455667788;

  psram_bus_if #(.REQ_DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .cfg_en_i      (cfg_en_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_wstrb_i   (req_wstrb_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .xfer_valid_o  (xfer_valid_o),
    .xfer_rdwr_o   (xfer_rdwr_o),
    .xfer_ready_i  (xfer_ready_i),
    .xfer_done_i   (xfer_done_i),
    .bus_addr_o    (bus_addr_o),
    .bus_wr_data_o (bus_wr_data_o),
    .bus_wr_mask_o (bus_wr_mask_o),
    .bus_rd_data_i (bus_rd_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expired(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Issue one request; expectations are queued at the accepting cycle.
  task automatic push(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                      input logic [7:0] ws, input logic issue, input logic exp_rsp,
                      input logic [63:0] exp_rd, input logic exp_err);
    int    n;
    rsp_t  r;
    xfer_t x;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_wstrb_i = ws;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      n++;
      if (n > 300) begin
        expired("push_accept");
        break;
      end
    end
    if (issue) begin
      x.rdwr = ~we; x.addr = addr; x.wdata = wd; x.mask = ws;
      xq.push_back(x);
    end
    if (exp_rsp) begin
      r.rdata = exp_rd; r.err = exp_err;
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        expired("drain");
        rsp_q.delete();
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Response monitor: every handshake must match the oldest expectation.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n_i && rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b, none expected", rsp_rdata_o, rsp_err_o);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, r.rdata);
          chk("rsp_err", 64'(rsp_err_o), 64'(r.err));
        end
      end
    end
  end

  // Core model: accept, check the presented head, hold it, pulse done.
  initial begin
    xfer_t x;
    logic  stable;
    logic  aborted;
    xfer_done_i   = 1'b0;
    bus_rd_data_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n_i && xfer_valid_o && xfer_ready_i) begin
        if (xq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got addr 0x%0h, no transfer expected", bus_addr_o);
        end else begin
          x = xq.pop_front();
          chk("xfer_rdwr", 64'(xfer_rdwr_o), 64'(x.rdwr));
          chk("bus_addr", 64'(bus_addr_o), 64'(x.addr));
          chk("bus_wr_data", bus_wr_data_o, x.wdata);
          chk("bus_wr_mask", 64'(bus_wr_mask_o), 64'(x.mask));
        end
        stable  = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < core_delay; i++) begin
          @(negedge clk);
          if (!rst_n_i) aborted = 1'b1;
          if (bus_addr_o !== x.addr || bus_wr_data_o !== x.wdata ||
              bus_wr_mask_o !== x.mask || xfer_rdwr_o !== x.rdwr) stable = 1'b0;
        end
        if (!aborted) chk("bus_stable_in_wait", 64'(stable), 64'd1);
        xfer_done_i   = 1'b1;
        bus_rd_data_i = core_rdata;
        @(negedge clk);
        xfer_done_i   = 1'b0;
        bus_rd_data_i = '0;
        if (aborted) chk("no_rsp_after_reset", 64'(rsp_valid_o), 64'd0);
        else         chk("rsp_latency", 64'(rsp_valid_o), 64'd1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i      = 1'b0;
    cfg_en_i     = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_wstrb_i  = '0;
    rsp_ready_i  = 1'b1;
    xfer_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n_i = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    chk("rst_xfer_valid", 64'(xfer_valid_o), 64'd0);
    chk("rst_xfer_rdwr", 64'(xfer_rdwr_o), 64'd1);
    chk("rst_bus_addr", 64'(bus_addr_o), 64'd0);
    @(posedge clk); #1;

    // Aligned read with issue latency check
    core_delay = 20;
    core_rdata = 64'h1122334455667788;
    push(1'b0, 32'h0000_0100, 64'd0, 8'h00, 1'b1, 1'b1, 64'h1122334455667788, 1'b0);
    @(negedge clk);
    chk("issue_latency_n1", 64'(xfer_valid_o), 64'd0);
    @(negedge clk);
    chk("issue_latency_n2", 64'(xfer_valid_o), 64'd1);
    drain();

    // Aligned write returns zero data even if the core drives read data
    core_rdata = 64'hDEAD_BEEF_0000_1111;
    @(posedge clk); #1;
    push(1'b1, 32'h0000_0008, 64'hA5A5A5A5A5A5A5A5, 8'h0F, 1'b1, 1'b1, 64'd0, 1'b0);
    drain();

    // Misaligned: error response, no transfer
    @(posedge clk); #1;
    push(1'b0, 32'h0000_0003, 64'd0, 8'h00, 1'b0, 1'b1, 64'd0, 1'b1);
    drain();

    // Back-pressure: two queued, third waits for a response handshake
    core_delay = 3;
    core_rdata = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    push(1'b0, 32'h0000_0200, 64'd0, 8'h00, 1'b1, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    push(1'b1, 32'h0000_0210, 64'h5555_6666_7777_8888, 8'hF0, 1'b1, 1'b1, 64'd0, 1'b0);
    @(negedge clk);
    chk("full_req_ready", 64'(req_ready_o), 64'd0);
    begin
      int n;
      n = 0;
      forever begin
        @(posedge clk); #1;
        if (rsp_valid_o) break;
        n++;
        if (n > 200) begin
          expired("bp_rsp_valid");
          break;
        end
      end
    end
    rsp_ready_i = 1'b1;
    chk("no_pass_through", 64'(req_ready_o), 64'd0);
    push(1'b0, 32'h0000_0220, 64'd0, 8'h00, 1'b1, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    drain();

    // Disabled controller: queued request errors out
    @(posedge clk); #1;
    cfg_en_i = 1'b0;
    push(1'b0, 32'h0000_0010, 64'd0, 8'h00, 1'b0, 1'b1, 64'd0, 1'b1);
    drain();

    // Enable dropped while waiting on the core: transfer still completes
    core_delay = 20;
    core_rdata = 64'hFEDC_BA98_7654_3210;
    @(posedge clk); #1;
    cfg_en_i = 1'b1;
    push(1'b0, 32'h0000_0020, 64'd0, 8'h00, 1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0);
    repeat (6) @(negedge clk);
    cfg_en_i = 1'b0;
    drain();
    cfg_en_i = 1'b1;

    // Reset while waiting on the core: no response, late done ignored
    @(posedge clk); #1;
    push(1'b0, 32'h0000_0040, 64'd0, 8'h00, 1'b1, 1'b0, 64'd0, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst_n_i = 1'b0;
    @(posedge clk);
    #1 rst_n_i = 1'b1;
    @(negedge clk);
    chk("wrst_req_ready", 64'(req_ready_o), 64'd1);
    chk("wrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("wrst_rsp_err", 64'(rsp_err_o), 64'd0);
    chk("wrst_xfer_valid", 64'(xfer_valid_o), 64'd0);
    chk("wrst_xfer_rdwr", 64'(xfer_rdwr_o), 64'd1);
    chk("wrst_bus_addr", 64'(bus_addr_o), 64'd0);
    repeat (30) @(negedge clk);
    chk("wrst_idle_rsp_valid", 64'(rsp_valid_o), 64'd0);

    // Normal operation after reset
    core_delay = 4;
    core_rdata = 64'h0;
    @(posedge clk); #1;
    push(1'b1, 32'h0000_0080, 64'h0F0F_0F0F_F0F0_F0F0, 8'hFF, 1'b1, 1'b1, 64'd0, 1'b0);
    drain();
    chk("end_xq_empty", 64'(xq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
